turbo_iter_sched: RTL and testbench
===================================

Name: turbo_iter_sched

Overview:
Iteration scheduler for the turbo decoder's single shared SISO core. For each frame it sequences half-iterations: half 0 uses natural order and half 1 uses QPP-interleaved order. It generates the SISO read addresses, counts full iterations and applies early termination. It then drives the hard-decision readout and signals frame completion with a one-cycle done pulse.

Parameters:
K, 40, frame length in symbols (K ≥ 8)
F1, 3, QPP linear coefficient (odd, coprime with K)
F2, 10, QPP quadratic coefficient
MAX_ITER, 8, maximum full iterations (1..15)
AW, $clog2(K), address width

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  reset, active-low, asynchronous
i_start  in  1  frame start request; ignored while o_busy=1
i_siso_ready  in  1  SISO accepts the current address
i_siso_done  in  1  SISO has finished the current half-iteration (1-cycle pulse)
i_early_stop  in  1  hard decisions stable; sampled only with i_siso_done in half 1
o_busy  out  1  frame in progress
o_siso_start  out  1  1-cycle pulse at the beginning of each half-iteration
o_half  out  1  0 = natural order, 1 = interleaved order
o_addr_valid  out  1  o_addr is valid
o_addr  out  AW  SISO symbol address
o_out_valid  out  1  readout address is valid
o_out_addr  out  AW  hard-decision readout address
o_iter_cnt  out  4  full iterations completed in the current frame
o_done  out  1  1-cycle pulse when the frame is complete

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; counters and QPP registers 0. Reset mid-frame abandons the frame; no o_done is issued.
- States: IDLE, START, ISSUE, WAIT, OUTPUT, DONE.
- IDLE:
  - i_start=1 → START, with half=0 and iter_cnt=0.
  - o_busy rises the cycle after i_start is sampled and stays 1 through DONE.
- START:
  - o_siso_start=1 for one cycle.
  - Index i is cleared; QPP registers initialise to pi=0, g=(F1+F2) mod K.
  - Next state is ISSUE.
- ISSUE:
  - o_addr_valid=1.
  - o_addr = i when half=0, pi when half=1.
  - On valid & i_siso_ready:
    - i increments.
    - pi' = (pi+g) mod K.
    - g' = (g + 2·F2 mod K) mod K.
  - Each mod is a single conditional subtract, because both operands are < K.
  - When ready is low, o_addr holds its value.
  - After index K−1 is accepted, next state is WAIT and o_addr_valid drops.
- WAIT:
  - Waits for i_siso_done; i_siso_done in any other state is ignored.
  - half=0: set half=1 and go to START.
  - half=1: iter_cnt increments. If i_early_stop=1 or the new iter_cnt = MAX_ITER, go to OUTPUT. Otherwise set half=0 and go to START.
- OUTPUT:
  - o_out_valid=1 for exactly K consecutive cycles, with o_out_addr = 0..K−1. There is no backpressure.
  - Next state is DONE.
- DONE:
  - o_done=1 for one cycle; o_busy=0 from the next cycle; state returns to IDLE.
  - o_iter_cnt holds its final value until the next i_start.
- i_start asserted in the DONE cycle is ignored; a new frame needs i_start while in IDLE.
- Throughput: with i_siso_ready=1 and no stall, each half takes 1 + K + (SISO latency) cycles.

Decomposition:
- Shared package: state enum, default K/F1/F2, the 2·F2 mod K constant, and an address-width helper.
- One natural sub-module, qpp_addr_gen. It holds the incremental pi/g registers with load (init) and advance (step) controls, and outputs pi. It is reusable by the encoder interleaver.

Test Plan:
- QPP sequence: K=40, F1=3, F2=10, ready=1 → half-1 addresses 0,13,6,19,… ; all 40 values distinct and covering 0..39.
- Full run: MAX_ITER=2, early_stop=0, siso_done pulsed 3 cycles after each WAIT entry → exactly 4 o_siso_start pulses, o_half toggles 0,1,0,1, o_iter_cnt=2, 40 o_out_valid cycles with addresses 0..39, then one o_done.
- Early stop: early_stop=1 with the first half-1 done → o_iter_cnt=1, no third o_siso_start, OUTPUT begins next cycle.
- Backpressure: i_siso_ready toggled 1,0,1,0 during ISSUE → o_addr is held while ready=0, no address is skipped or duplicated, and exactly 40 handshakes occur per half.
- Spurious inputs: i_start while busy, and i_siso_done during ISSUE → no effect on state or counters.
- Reset at the mid-point of half 1 → all outputs 0 immediately, no o_done; a new i_start runs a clean frame from half 0.

Source files
------------

// File: rtl/turbo_iter_sched_pkg.sv
// Shared types and constants for the turbo decoder iteration scheduler
// and its QPP address generator.
package turbo_iter_sched_pkg;

  localparam int unsigned K_DEF  = 40;
  localparam int unsigned F1_DEF = 3;
  localparam int unsigned F2_DEF = 10;
  localparam int unsigned DG_DEF = (2 * F2_DEF) % K_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_DONE
  } state_t;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Second difference of the QPP polynomial: the constant increment of g.
  function automatic int unsigned qpp_dg(input int unsigned k, input int unsigned f2);
    return (2 * f2) % k;
  endfunction

endpackage

// File: rtl/turbo_iter_sched_qpp_addr_gen.sv
// Incremental QPP interleaver address generator: pi(i) = (F1*i + F2*i^2) mod K
// produced with one add and one conditional subtract per step.
module qpp_addr_gen
  import turbo_iter_sched_pkg::*;
#(
  parameter int unsigned K  = K_DEF,
  parameter int unsigned F1 = F1_DEF,
  parameter int unsigned F2 = F2_DEF,
  parameter int unsigned AW = addr_w(K)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_init,
  input  logic          i_step,
  output logic [AW-1:0] o_pi
);

  localparam logic [AW:0]   C_K  = (AW + 1)'(K);
  localparam logic [AW-1:0] C_G0 = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] C_DG = AW'(qpp_dg(K, F2));

  logic [AW-1:0] r_pi;
  logic [AW-1:0] r_g;
  logic [AW:0]   w_pi_sum;
  logic [AW:0]   w_g_sum;
  logic [AW-1:0] w_pi_nxt;
  logic [AW-1:0] w_g_nxt;

  // Both operands are already < K, so one conditional subtract is a full mod.
  always_comb begin
    w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
    w_g_sum  = {1'b0, r_g} + {1'b0, C_DG};
    w_pi_nxt = (w_pi_sum >= C_K) ? AW'(w_pi_sum - C_K) : w_pi_sum[AW-1:0];
    w_g_nxt  = (w_g_sum >= C_K) ? AW'(w_g_sum - C_K) : w_g_sum[AW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pi <= '0;
      r_g  <= '0;
    end else if (i_init) begin
      r_pi <= '0;
      r_g  <= C_G0;
    end else if (i_step) begin
      r_pi <= w_pi_nxt;
      r_g  <= w_g_nxt;
    end
  end

  assign o_pi = r_pi;

endmodule

// File: rtl/turbo_iter_sched.sv
// Turbo decoder iteration scheduler: sequences natural/interleaved half
// iterations on one SISO core, applies early termination, then reads out.
module turbo_iter_sched
  import turbo_iter_sched_pkg::*;
#(
  parameter int unsigned K        = K_DEF,
  parameter int unsigned F1       = F1_DEF,
  parameter int unsigned F2       = F2_DEF,
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned AW       = addr_w(K)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_siso_ready,
  input  logic          i_siso_done,
  input  logic          i_early_stop,
  output logic          o_busy,
  output logic          o_siso_start,
  output logic          o_half,
  output logic          o_addr_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_out_valid,
  output logic [AW-1:0] o_out_addr,
  output logic [3:0]    o_iter_cnt,
  output logic          o_done
);

  localparam logic [AW-1:0] C_LAST = AW'(K - 1);
  localparam logic [3:0]    C_MAX  = 4'(MAX_ITER);

  state_t        r_state;
  logic          r_busy;
  logic          r_siso_start;
  logic          r_half;
  logic          r_addr_valid;
  logic [AW-1:0] r_idx;
  logic          r_out_valid;
  logic [AW-1:0] r_out_addr;
  logic [3:0]    r_iter;
  logic          r_done;

  logic          w_init;
  logic          w_step;
  logic [AW-1:0] w_pi;
  logic [3:0]    w_iter_nxt;

  assign w_init     = (r_state == S_START);
  assign w_step     = r_addr_valid && i_siso_ready;
  assign w_iter_nxt = r_iter + 4'd1;

  qpp_addr_gen #(
    .K  (K),
    .F1 (F1),
    .F2 (F2),
    .AW (AW)
  ) u_qpp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_init  (w_init),
    .i_step  (w_step),
    .o_pi    (w_pi)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_siso_start <= 1'b0;
      r_half       <= 1'b0;
      r_addr_valid <= 1'b0;
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_iter       <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state      <= S_START;
            r_busy       <= 1'b1;
            r_siso_start <= 1'b1;
            r_half       <= 1'b0;
            r_iter       <= '0;
          end
        end
        S_START: begin
          r_siso_start <= 1'b0;
          r_idx        <= '0;
          r_addr_valid <= 1'b1;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_step) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == C_LAST) begin
              r_addr_valid <= 1'b0;
              r_state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_siso_done) begin
            if (!r_half) begin
              r_half       <= 1'b1;
              r_siso_start <= 1'b1;
              r_state      <= S_START;
            end else begin
              r_iter <= w_iter_nxt;
              if (i_early_stop || (w_iter_nxt == C_MAX)) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= '0;
                r_state     <= S_OUTPUT;
              end else begin
                r_half       <= 1'b0;
                r_siso_start <= 1'b1;
                r_state      <= S_START;
              end
            end
          end
        end
        S_OUTPUT: begin
          if (r_out_addr == C_LAST) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_out_addr <= r_out_addr + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_siso_start = r_siso_start;
  assign o_half       = r_half;
  assign o_addr_valid = r_addr_valid;
  assign o_addr       = r_addr_valid ? (r_half ? w_pi : r_idx) : '0;
  assign o_out_valid  = r_out_valid;
  assign o_out_addr   = r_out_addr;
  assign o_iter_cnt   = r_iter;
  assign o_done       = r_done;

endmodule

// File: tb/tb_turbo_iter_sched.sv
// Scoreboard bench for turbo_iter_sched: expected SISO and readout addresses
// are queued per half-iteration and popped as the DUT hands them over.
module tb_turbo_iter_sched;

  localparam int K    = 40;
  localparam int F1   = 3;
  localparam int F2   = 10;
  localparam int MAXI = 2;
  localparam int AW   = 6;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic          i_siso_ready;
  logic          i_siso_done;
  logic          i_early_stop;
  logic          o_busy;
  logic          o_siso_start;
  logic          o_half;
  logic          o_addr_valid;
  logic [AW-1:0] o_addr;
  logic          o_out_valid;
  logic [AW-1:0] o_out_addr;
  logic [3:0]    o_iter_cnt;
  logic          o_done;

  turbo_iter_sched #(
    .K        (K),
    .F1       (F1),
    .F2       (F2),
    .MAX_ITER (MAXI)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_siso_ready (i_siso_ready),
    .i_siso_done  (i_siso_done),
    .i_early_stop (i_early_stop),
    .o_busy       (o_busy),
    .o_siso_start (o_siso_start),
    .o_half       (o_half),
    .o_addr_valid (o_addr_valid),
    .o_addr       (o_addr),
    .o_out_valid  (o_out_valid),
    .o_out_addr   (o_out_addr),
    .o_iter_cnt   (o_iter_cnt),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            q_addr[$];
  int            q_out[$];
  int            n_start = 0;
  int            n_done  = 0;
  int            n_out   = 0;
  int            n_hs    = 0;
  logic          last_ss = 1'b0;
  logic          last_ov = 1'b0;
  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [AW-1:0] p_addr  = '0;
  logic [63:0]   seen    = '0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Sample all outputs mid-cycle and score handshakes against the queues.
  task automatic mon();
    int e;
    last_ss = o_siso_start;
    last_ov = o_out_valid;
    if (o_siso_start) begin
      n_start++;
      seen = '0;
    end
    if (o_done) n_done++;
    if (p_valid && !p_ready && o_addr_valid) check("addr_hold", int'(o_addr), int'(p_addr));
    if (o_addr_valid && i_siso_ready) begin
      e = (q_addr.size() > 0) ? q_addr.pop_front() : -1;
      check("addr", int'(o_addr), e);
      if (o_half) seen[o_addr] = 1'b1;
      n_hs++;
    end
    if (o_out_valid) begin
      e = (q_out.size() > 0) ? q_out.pop_front() : -1;
      check("out_addr", int'(o_out_addr), e);
      n_out++;
    end
    p_valid = o_addr_valid;
    p_ready = i_siso_ready;
    p_addr  = o_addr;
  endtask

  task automatic cycle();
    @(negedge i_clk);
    mon();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_frame(input int exp_iters, input bit early, input bit bp,
                           input bit spur, input bit rst_mid);
    int halves, cyc, hs_base, b_start, b_done, b_out, b_hs;
    halves  = exp_iters * 2;
    b_start = n_start;
    b_done  = n_done;
    b_out   = n_out;
    b_hs    = n_hs;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    for (int h = 0; h < halves; h++) begin
      for (int i = 0; i < K; i++)
        q_addr.push_back((h % 2 == 0) ? i : (F1 * i + F2 * i * i) % K);
      cyc = 0;
      do begin
        cycle();
        cyc++;
      end while (!last_ss && cyc < 20);
      check("siso_start", int'(last_ss), 1);
      check("half", int'(o_half), h % 2);
      check("busy", int'(o_busy), 1);
      hs_base = n_hs;
      cyc = 0;
      while (n_hs - hs_base < K && cyc < 400) begin
        if (rst_mid && h == 1 && n_hs - hs_base == K / 2) begin
          i_rst_n = 1'b0;
          #1;
          check("rst_outs", int'({o_busy, o_siso_start, o_half, o_addr_valid, o_addr,
                                  o_out_valid, o_out_addr, o_iter_cnt, o_done}), 0);
          cycle();
          cycle();
          check("rst_no_done", n_done - b_done, 0);
          check("rst_iter", int'(o_iter_cnt), 0);
          i_rst_n = 1'b1;
          q_addr.delete();
          q_out.delete();
          return;
        end
        i_siso_ready = bp ? (cyc % 2 == 0) : 1'b1;
        i_siso_done  = spur && h == 0 && cyc == 5;
        i_start      = spur && cyc == 7;
        cycle();
        cyc++;
      end
      i_siso_ready = 1'b1;
      i_siso_done  = 1'b0;
      i_start      = 1'b0;
      check("hs_count", n_hs - hs_base, K);
      if (h % 2 == 1) check("qpp_cover", $countones(seen), K);
      if (h == halves - 1)
        for (int i = 0; i < K; i++) q_out.push_back(i);
      cycle();
      cycle();
      i_siso_done  = 1'b1;
      i_early_stop = early && (h == halves - 1);
      cycle();
      i_siso_done  = 1'b0;
      i_early_stop = 1'b0;
      if (h == halves - 1) begin
        cycle();
        check("out_next", int'(last_ov), 1);
      end
    end
    cyc = 0;
    while (n_done == b_done && cyc < 100) begin
      cycle();
      cyc++;
    end
    check("done_seen", n_done - b_done, 1);
    check("iter_cnt", int'(o_iter_cnt), exp_iters);
    check("starts", n_start - b_start, halves);
    check("out_count", n_out - b_out, K);
    check("hs_total", n_hs - b_hs, halves * K);
    check("addr_q_left", q_addr.size(), 0);
    check("out_q_left", q_out.size(), 0);
    cycle();
    cycle();
    check("idle_busy", int'(o_busy), 0);
    check("single_done", n_done - b_done, 1);
    check("iter_hold", int'(o_iter_cnt), exp_iters);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_siso_ready = 1'b1;
    i_siso_done  = 1'b0;
    i_early_stop = 1'b0;
    repeat (3) cycle();
    check("reset_outs", int'({o_busy, o_siso_start, o_half, o_addr_valid, o_addr,
                              o_out_valid, o_out_addr, o_iter_cnt, o_done}), 0);
    i_rst_n = 1'b1;
    cycle();
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
